// File: rtl/psum_collect.sv
// Ping-pong partial-sum collector: accumulates PE column psums over input-channel
// passes into one bank while the other drains a finished output-channel tile.
//   state   | meaning
//   S_IDLE  | no tile draining; waiting for rd bank to be FULL
//   S_DRAIN | streaming rd bank beats downstream
module psum_collect #(
  parameter int COL        = 8,
  parameter int TILE_LEN   = 16,
  parameter int PSUM_WIDTH = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [COL-1:0]                pvalid_i,
  input  logic [COL*PSUM_WIDTH-1:0]     psum_in_i,
  input  logic                          pass_end_i,
  input  logic                          oc_end_i,
  input  logic                          conv_end_i,
  output logic                          ofm_valid_o,
  input  logic                          ofm_ready_i,
  output logic [COL*PSUM_WIDTH-1:0]     ofm_data_o,
  output logic [COL-1:0]                ofm_mask_o,
  output logic [$clog2(TILE_LEN)-1:0]   ofm_idx_o,
  output logic                          ofm_last_o,
  output logic                          ofm_done_o,
  output logic                          ovf_o
);
  localparam int IW = $clog2(TILE_LEN);
  localparam int BW = $clog2(TILE_LEN + 1);

  typedef enum logic [1:0] {B_FREE, B_ACC, B_FULL, B_DRAIN} bank_st_e;
  typedef enum logic {S_IDLE, S_DRAIN} drain_st_e;

  logic [PSUM_WIDTH-1:0] acc_q [2][TILE_LEN][COL];

  bank_st_e        bst_q   [2];
  bank_st_e        bst_d   [2];
  logic [BW-1:0]   nbeat_q [2];
  logic [BW-1:0]   nbeat_d [2];
  logic [COL-1:0]  lmask_q [2];
  logic [COL-1:0]  lmask_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [BW-1:0]   bidx_q, bidx_d;
  logic [IW-1:0]   ridx_q, ridx_d;
  logic            first_q, first_d;
  logic            fpass_q, fpass_d;
  logic            done_pend_q, done_pend_d;
  logic            ovf_q, ovf_d;
  drain_st_e       state_q, state_d;

  logic beat, wr_ok, acc_we, fill, pend, oc, conv, hs, last;

  // first_q marks "next beat opens an output channel"; fpass_q keeps the
  // overwrite behaviour alive for the remaining beats of that first pass.
  assign beat   = |pvalid_i;
  assign wr_ok  = ((bst_q[wr_bank_q] == B_FREE) || (bst_q[wr_bank_q] == B_ACC)) &&
                  (bidx_q < BW'(TILE_LEN));
  assign acc_we = beat && wr_ok;
  assign fill   = first_q || fpass_q;
  assign pend   = beat && pass_end_i;
  assign oc     = pend && oc_end_i;
  assign conv   = oc && conv_end_i;
  assign last   = (state_q == S_DRAIN) && (BW'(ridx_q) == nbeat_q[rd_bank_q] - BW'(1));
  assign hs     = (state_q == S_DRAIN) && ofm_ready_i;

  assign ofm_done_o  = done_pend_q && (bst_q[0] == B_FREE) && (bst_q[1] == B_FREE);
  assign ovf_o       = ovf_q;
  assign ofm_valid_o = (state_q == S_DRAIN);
  assign ofm_last_o  = last;
  assign ofm_idx_o   = (state_q == S_DRAIN) ? ridx_q : '0;
  assign ofm_mask_o  = (state_q == S_DRAIN) ? lmask_q[rd_bank_q] : '0;

  always_comb begin
    ofm_data_o = '0;
    if (state_q == S_DRAIN) begin
      for (int l = 0; l < COL; l++) begin
        ofm_data_o[l*PSUM_WIDTH +: PSUM_WIDTH] = acc_q[rd_bank_q][ridx_q][l];
      end
    end
  end

  always_comb begin
    bst_d       = bst_q;
    nbeat_d     = nbeat_q;
    lmask_d     = lmask_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bidx_d      = bidx_q;
    ridx_d      = ridx_q;
    first_d     = first_q;
    fpass_d     = fpass_q;
    done_pend_d = done_pend_q;
    ovf_d       = ovf_q;
    state_d     = state_q;

    if (beat) begin
      if (pass_end_i) begin
        bidx_d = '0;
      end else if (bidx_q != BW'(TILE_LEN)) begin
        bidx_d = bidx_q + BW'(1);
      end
      if (first_q) begin
        first_d = 1'b0;
        fpass_d = 1'b1;
      end
      if (pass_end_i) fpass_d = 1'b0;
      if (oc)         first_d = 1'b1;
      if (!wr_ok)     ovf_d   = 1'b1;
    end

    if (acc_we) begin
      if (first_q) begin
        bst_d[wr_bank_q]   = B_ACC;
        lmask_d[wr_bank_q] = pvalid_i;
      end else if (fpass_q) begin
        lmask_d[wr_bank_q] = lmask_q[wr_bank_q] | pvalid_i;
      end
      if (pass_end_i && fill) nbeat_d[wr_bank_q] = bidx_q + BW'(1);
      if (oc) begin
        bst_d[wr_bank_q] = B_FULL;
        wr_bank_d        = ~wr_bank_q;
      end
    end

    // Drain side only touches FULL/DRAIN banks, the write side only FREE/ACC,
    // so both may update their own bank in the same cycle.
    case (state_q)
      S_IDLE: begin
        if (bst_q[rd_bank_q] == B_FULL) begin
          bst_d[rd_bank_q] = B_DRAIN;
          ridx_d           = '0;
          state_d          = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs) begin
          if (last) begin
            bst_d[rd_bank_q] = B_FREE;
            rd_bank_d        = ~rd_bank_q;
            ridx_d           = '0;
            state_d          = S_IDLE;
          end else begin
            ridx_d = ridx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ofm_done_o) done_pend_d = 1'b0;
    if (conv)       done_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        bst_q[b]   <= B_FREE;
        nbeat_q[b] <= '0;
        lmask_q[b] <= '0;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bidx_q      <= '0;
      ridx_q      <= '0;
      first_q     <= 1'b1;
      fpass_q     <= 1'b0;
      done_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      bst_q       <= bst_d;
      nbeat_q     <= nbeat_d;
      lmask_q     <= lmask_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bidx_q      <= bidx_d;
      ridx_q      <= ridx_d;
      first_q     <= first_d;
      fpass_q     <= fpass_d;
      done_pend_q <= done_pend_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
    end
  end

  // Accumulator RAM has no reset; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    if (acc_we) begin
      for (int l = 0; l < COL; l++) begin
        if (fill) begin
          acc_q[wr_bank_q][bidx_q[IW-1:0]][l] <=
            pvalid_i[l] ? psum_in_i[l*PSUM_WIDTH +: PSUM_WIDTH] : '0;
        end else if (pvalid_i[l]) begin
          acc_q[wr_bank_q][bidx_q[IW-1:0]][l] <=
            acc_q[wr_bank_q][bidx_q[IW-1:0]][l] + psum_in_i[l*PSUM_WIDTH +: PSUM_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_collect.sv
// Bench for psum_collect: table of tile vectors with a queue scoreboard, plus
// hand-written backpressure, overflow, reset-mid-drain and done sequences.
module tb_psum_collect;
  localparam int COL = 8;
  localparam int TL  = 16;
  localparam int PW  = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [COL-1:0]      pvalid;
  logic [COL*PW-1:0]   psum;
  logic                pass_end, oc_end, conv_end;
  logic                ofm_valid, ofm_ready;
  logic [COL*PW-1:0]   ofm_data;
  logic [COL-1:0]      ofm_mask;
  logic [3:0]          ofm_idx;
  logic                ofm_last, ofm_done, ovf;

  psum_collect #(.COL(COL), .TILE_LEN(TL), .PSUM_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst), .pvalid_i(pvalid), .psum_in_i(psum),
    .pass_end_i(pass_end), .oc_end_i(oc_end), .conv_end_i(conv_end),
    .ofm_valid_o(ofm_valid), .ofm_ready_i(ofm_ready), .ofm_data_o(ofm_data),
    .ofm_mask_o(ofm_mask), .ofm_idx_o(ofm_idx), .ofm_last_o(ofm_last),
    .ofm_done_o(ofm_done), .ovf_o(ovf)
  );

  typedef struct {
    int         nb;
    logic [7:0] pv;
    logic [7:0] pv2;
    int         npass;
    logic [23:0] base;
    int         ls;
    int         bs;
    bit         gap;
    bit         conv;
  } vec_t;

  typedef struct {
    logic [COL*PW-1:0] data;
    logic [7:0]        mask;
    logic [3:0]        idx;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   done_gap = -1;
  int   last_hs_cyc = -100;
  bit   bp_on = 1'b0;
  bit   hold_v = 1'b0;
  exp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] lane_val(vec_t v, int b, int l);
    return v.base + 24'(v.ls * l) + 24'(v.bs * b);
  endfunction

  function automatic logic [7:0] beat_pv(vec_t v, int b);
    return (b % 2 == 1) ? v.pv2 : v.pv;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_exp(vec_t v);
    exp_t e;
    logic [7:0]  m;
    logic [7:0]  bp;
    logic [31:0] prod;
    m = v.pv;
    if (v.nb > 1) m = m | v.pv2;
    for (int b = 0; b < v.nb; b++) begin
      bp = beat_pv(v, b);
      e.data = '0;
      for (int l = 0; l < COL; l++) begin
        prod = 32'(v.npass) * {8'h00, lane_val(v, b, l)};
        if (bp[l]) e.data[l*PW +: PW] = prod[23:0];
      end
      e.mask = m;
      e.idx  = 4'(b);
      e.last = (b == v.nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_oc(vec_t v, bit push, bit chk_first_ovf);
    if (push) push_exp(v);
    for (int p = 0; p < v.npass; p++) begin
      for (int b = 0; b < v.nb; b++) begin
        if (v.gap && p == 0 && b == 3) begin
          pvalid = '0; pass_end = 1'b1; oc_end = 1'b1; conv_end = 1'b0;
          @(posedge clk); #1;
        end
        pvalid = beat_pv(v, b);
        for (int l = 0; l < COL; l++) psum[l*PW +: PW] = lane_val(v, b, l);
        pass_end = (b == v.nb - 1);
        oc_end   = pass_end && (p == v.npass - 1);
        conv_end = oc_end && v.conv;
        @(posedge clk); #1;
        if (chk_first_ovf && p == 0 && b == 0) check("ovf_first_beat", 32'(ovf), 32'd1);
      end
    end
    pvalid = '0; psum = '0; pass_end = 1'b0; oc_end = 1'b0; conv_end = 1'b0;
  endtask

  task automatic wait_empty(string name, int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || ofm_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s drain timeout left=%0d want=0", name, sb.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_on) ofm_ready = ~ofm_ready;
    end
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          total++;
          if (!ofm_valid || ofm_data !== held.data || ofm_mask !== held.mask ||
              ofm_idx !== held.idx || ofm_last !== held.last) begin
            bad++;
            $display("FAIL stall_hold got v=%0b idx=%0d mask=%h want v=1 idx=%0d mask=%h",
                     ofm_valid, ofm_idx, ofm_mask, held.idx, held.mask);
          end
        end
        if (ofm_valid && ofm_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat got idx=%0d want none", ofm_idx);
          end else begin
            e = sb.pop_front();
            if (ofm_data !== e.data || ofm_mask !== e.mask || ofm_idx !== e.idx ||
                ofm_last !== e.last) begin
              bad++;
              $display("FAIL ofm_beat got d=%h m=%h i=%0d l=%0b want d=%h m=%h i=%0d l=%0b",
                       ofm_data, ofm_mask, ofm_idx, ofm_last, e.data, e.mask, e.idx, e.last);
            end
          end
          if (ofm_last) last_hs_cyc = cyc;
        end
        if (ofm_done) begin
          done_cnt++;
          done_gap = cyc - last_hs_cyc;
        end
        hold_v     = ofm_valid && !ofm_ready;
        held.data  = ofm_data;
        held.mask  = ofm_mask;
        held.idx   = ofm_idx;
        held.last  = ofm_last;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t va, vb, vc;
    int   vcount;

    tbl[0] = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:1, base:24'd1,       ls:1, bs:0, gap:1'b0, conv:1'b0};
    tbl[1] = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:3, base:24'd5,       ls:0, bs:0, gap:1'b0, conv:1'b0};
    tbl[2] = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:3, base:24'd2,       ls:0, bs:0, gap:1'b0, conv:1'b0};
    tbl[3] = '{nb:10, pv:8'h0F, pv2:8'h0F, npass:1, base:24'd1,       ls:1, bs:0, gap:1'b0, conv:1'b0};
    tbl[4] = '{nb:12, pv:8'hA5, pv2:8'h5A, npass:2, base:24'hFFFFF0,  ls:3, bs:7, gap:1'b1, conv:1'b0};
    tbl[5] = '{nb:1,  pv:8'h80, pv2:8'h80, npass:4, base:24'h123456,  ls:0, bs:0, gap:1'b0, conv:1'b0};
    tbl[6] = '{nb:16, pv:8'h3C, pv2:8'hC3, npass:3, base:24'h7FFFFF,  ls:1, bs:1, gap:1'b0, conv:1'b0};

    rst = 1'b1; pvalid = '0; psum = '0; pass_end = 1'b0; oc_end = 1'b0;
    conv_end = 1'b0; ofm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ofm_valid), 32'd0);
    check("rst_last",  32'(ofm_last),  32'd0);
    check("rst_done",  32'(ofm_done),  32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_idx",   32'(ofm_idx),   32'd0);
    check("rst_mask",  32'(ofm_mask),  32'd0);
    check("rst_data",  32'(|ofm_data), 32'd0);
    rst = 1'b0;
    ofm_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive_oc(tbl[i], 1'b1, 1'b0);
      wait_empty($sformatf("drain_vec%0d", i), 200);
    end
    check("ovf_after_table", 32'(ovf), 32'd0);

    // Backpressure: ready toggles while the next oc fills the other bank.
    va = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:1, base:24'd9, ls:2, bs:1, gap:1'b0, conv:1'b0};
    vb = '{nb:8,  pv:8'hFF, pv2:8'hFF, npass:2, base:24'd3, ls:1, bs:5, gap:1'b0, conv:1'b0};
    bp_on = 1'b1;
    drive_oc(va, 1'b1, 1'b0);
    drive_oc(vb, 1'b1, 1'b0);
    check("ovf_bp", 32'(ovf), 32'd0);
    wait_empty("drain_bp", 400);
    bp_on = 1'b0;
    ofm_ready = 1'b1;

    // Overflow: both banks held, third oc must be dropped.
    ofm_ready = 1'b0;
    va = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:1, base:24'h000100, ls:1, bs:1, gap:1'b0, conv:1'b0};
    vb = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:1, base:24'h000200, ls:1, bs:1, gap:1'b0, conv:1'b0};
    vc = '{nb:16, pv:8'hFF, pv2:8'hFF, npass:1, base:24'h000300, ls:1, bs:1, gap:1'b0, conv:1'b0};
    drive_oc(va, 1'b1, 1'b0);
    drive_oc(vb, 1'b1, 1'b0);
    check("ovf_before_third", 32'(ovf), 32'd0);
    drive_oc(vc, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    ofm_ready = 1'b1;
    wait_empty("drain_ovf", 200);
    check("ovf_sticky", 32'(ovf), 32'd1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Reset in the middle of a drain abandons the tile.
    ofm_ready = 1'b0;
    drive_oc(va, 1'b0, 1'b0);
    vcount = 0;
    while (!ofm_valid && vcount < 20) begin
      @(posedge clk); #1;
      vcount++;
    end
    check("middrain_valid", 32'(ofm_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ofm_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      if (ofm_valid) vcount++;
      @(posedge clk); #1;
    end
    check("postrst_no_valid", 32'(vcount), 32'd0);
    check("done_none_yet", 32'(done_cnt), 32'd0);

    // conv_end on the second oc: one done pulse right after its last handshake.
    vb.conv = 1'b1;
    drive_oc(va, 1'b1, 1'b0);
    drive_oc(vb, 1'b1, 1'b0);
    wait_empty("drain_done", 200);
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_gap",   32'(done_gap), 32'd1);
    check("ovf_done",   32'(ovf),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_collect.md
PSUM_COLLECT -- requirements
Module: psum_collect

Interface
REQ-001 Parameters SHALL be: COL = 8, the lane count (PE columns); TILE_LEN = 16, the beats per pass; PSUM_WIDTH = 24, the per-lane partial-sum width.
REQ-002 Ports SHALL be clk input 1 (sole clock); rst input 1 (synchronous, active-high reset).
REQ-003 Upstream ports SHALL be pvalid in COL (per-lane beat valid); psum_in in COL*PSUM_WIDTH (lane i at bits [i*PSUM_WIDTH +: PSUM_WIDTH]); pass_end in 1 (marks the final beat of an input-channel pass); oc_end in 1 (final pass of an output channel, valid only with pass_end); conv_end in 1 (final output channel of the conv, valid only with oc_end).
REQ-004 Downstream ports SHALL be ofm_valid out 1; ofm_ready in 1; ofm_data out COL*PSUM_WIDTH; ofm_mask out COL (lanes written in the tile); ofm_idx out $clog2(TILE_LEN) (beat index); ofm_last out 1; ofm_done out 1 (pulse); ovf out 1 (sticky error).

Function
REQ-005 Storage SHALL be two banks of TILE_LEN x COL x PSUM_WIDTH accumulators, used ping-pong: wr_bank accumulates while rd_bank drains.
REQ-006 Each bank SHALL hold state FREE, ACC, FULL or DRAIN, plus beat count nbeat (1..TILE_LEN) and lane mask lmask.
REQ-007 A beat SHALL be a cycle with |pvalid = 1; beat index bidx SHALL start at 0 and increment by 1 per beat.
REQ-008 bidx SHALL return to 0 on the cycle after pass_end.
REQ-009 On the first pass of an output channel (flag first = 1), lanes with pvalid[i] = 1 SHALL write psum_in lane i, and lanes with pvalid[i] = 0 SHALL write 0.
REQ-010 On later passes, lanes with pvalid[i] = 1 SHALL add psum_in (modulo 2^PSUM_WIDTH, no saturation), and lanes with pvalid[i] = 0 SHALL hold.
REQ-011 first SHALL be 1 after reset and 1 after oc_end, and SHALL clear on the first beat; the first beat SHALL move a FREE wr_bank to ACC.
REQ-012 During the first pass, lmask SHALL OR in pvalid per beat, and nbeat SHALL be captured as bidx + 1 at pass_end.
REQ-013 pass_end SHALL be honoured only when coincident with a beat; pass_end without a beat SHALL be ignored.
REQ-014 On oc_end, wr_bank SHALL become FULL and wr_bank SHALL toggle, taking effect next cycle.
REQ-015 A beat SHALL be dropped and ovf set to 1 if the targeted wr_bank is FULL or DRAIN, or if bidx = TILE_LEN.
REQ-016 ovf SHALL clear only on rst.
REQ-017 The drain FSM SHALL have states IDLE and DRAIN.
REQ-018 In IDLE, the FSM SHALL enter DRAIN the cycle after rd_bank becomes FULL, setting that bank to DRAIN with ridx = 0.
REQ-019 In DRAIN, ofm_valid SHALL be 1, ofm_data SHALL equal bank[rd_bank][ridx], ofm_idx SHALL equal ridx, and ofm_mask SHALL equal lmask.
REQ-020 ofm_last SHALL equal (ridx = nbeat - 1).
REQ-021 On ofm_valid & ofm_ready, ridx SHALL increment; ofm_data, ofm_idx, ofm_mask and ofm_last SHALL be stable while ofm_valid & !ofm_ready.
REQ-022 On a handshake with ofm_last, the bank SHALL become FREE, rd_bank SHALL toggle, and the FSM SHALL return to IDLE, giving one bubble cycle minimum between tiles.
REQ-023 conv_end SHALL set done_pend.
REQ-024 ofm_done SHALL pulse for 1 cycle when done_pend = 1 and both banks are FREE, and done_pend SHALL clear in the same cycle.
REQ-025 A beat into a bank and a drain release of the other bank in the same cycle SHALL both take effect.
REQ-026 oc_end and the DRAIN-to-FREE transition of the other bank in the same cycle SHALL make that bank the next wr_bank with no ovf.

Reset
REQ-027 On rst, the following SHALL clear: bank states to FREE, wr_bank = rd_bank = 0, bidx = ridx = 0, first = 1, done_pend = 0, FSM = IDLE.
REQ-028 On rst, outputs SHALL be ofm_valid = 0, ofm_last = 0, ofm_done = 0, ovf = 0, ofm_idx = 0, ofm_mask = 0, ofm_data = 0.
REQ-029 Accumulator contents SHALL be don't-care after reset.
REQ-030 rst mid-drain SHALL abandon the tile with no further ofm_valid.

Verification
REQ-031 Single pass: 16 beats, pvalid = 0xFF, lane i = i + 1, pass_end + oc_end on beat 15, ofm_ready = 1 -> 16 beats, each lane i = i + 1, ofm_mask = 0xFF, ofm_last on idx 15, ovf = 0.
REQ-032 Accumulate: 3 passes of 16 beats, each psum = 5 -> all outputs 15; a second oc with psum = 2 x 3 passes -> all outputs 6.
REQ-033 Partial tile: 10 beats, pvalid = 0x0F, one pass -> 10 output beats, ofm_mask = 0x0F, lanes 4..7 = 0, ofm_last at idx 9.
REQ-034 Backpressure: ofm_ready toggling 1/0 every cycle -> no data change while stalled; the next oc accumulates into the other bank concurrently.
REQ-035 Overflow: ofm_ready = 0, three complete ocs -> ovf = 1 on the first beat of the third oc, and the first two tiles drain intact once ready rises.
REQ-036 Done: conv_end with oc_end, ofm_ready = 1 -> ofm_done is a single pulse one cycle after the final tile's ofm_last handshake.
